// File: rtl/pipe_pkg.sv
// pipe_pkg: shared polarity constants, ALU op codes, per-stage control bundles
// and their bubble values, and forwarding select encodings for pipe_ctrl.
`default_nettype none

package pipe_pkg;

   // Decoder control lines are active-low: 0 = activo, 1 = desactivo.
   localparam logic ACTIVO    = 1'b0;
   localparam logic DESACTIVO = 1'b1;

   localparam int REG_W = 5;
   localparam int ALU_W = 3;

   localparam logic [ALU_W-1:0] ALU_NOP     = 3'b000;
   localparam logic [ALU_W-1:0] ALU_ADD     = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SUB     = 3'b010;
   localparam logic [ALU_W-1:0] ALU_AND     = 3'b011;
   localparam logic [ALU_W-1:0] ALU_OR      = 3'b100;
   localparam logic [ALU_W-1:0] ALU_SLT     = 3'b101;
   localparam logic [ALU_W-1:0] ALU_COMPARE = 3'b110;

   typedef logic [REG_W-1:0] reg_idx_t;

   typedef struct packed {
      logic [ALU_W-1:0] alu_fun;
      logic             sel_alu;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_rd;
      logic mem_wr;
      logic w_h;
   } mem_ctrl_t;

   typedef struct packed {
      logic dir_wb;
      logic reg_wr;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
      reg_idx_t  dest;
      reg_idx_t  rs;
      reg_idx_t  rt;
   } id_ex_t;

   typedef struct packed {
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
      reg_idx_t  dest;
   } ex_mem_t;

   typedef struct packed {
      wb_ctrl_t wb;
      reg_idx_t dest;
   } mem_wb_t;

   localparam ex_ctrl_t  EX_BUBBLE  = '{alu_fun: ALU_NOP, sel_alu: 1'b0};
   localparam mem_ctrl_t MEM_BUBBLE = '{mem_rd: DESACTIVO, mem_wr: DESACTIVO, w_h: 1'b0};
   localparam wb_ctrl_t  WB_BUBBLE  = '{dir_wb: 1'b1, reg_wr: DESACTIVO};

   localparam id_ex_t ID_EX_BUBBLE = '{
      ex: EX_BUBBLE, mem: MEM_BUBBLE, wb: WB_BUBBLE, dest: '0, rs: '0, rt: '0
   };
   localparam ex_mem_t EX_MEM_BUBBLE = '{mem: MEM_BUBBLE, wb: WB_BUBBLE, dest: '0};
   localparam mem_wb_t MEM_WB_BUBBLE = '{wb: WB_BUBBLE, dest: '0};

   typedef enum logic [1:0] {
      FWD_BANK  = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_t;

   // A stage is a usable forwarding source only if it writes a non-zero register.
   function automatic logic writes_reg(input logic reg_wr_n, input reg_idx_t dest);
      return (reg_wr_n == ACTIVO) && (dest != '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decoder-side inputs and stage control outputs of pipe_ctrl.
`default_nettype none

interface pipe_ctrl_if;

   logic [4:0] ctrl_EXE;
   logic [2:0] ctrl_MEM;
   logic [1:0] ctrl_WB;
   logic       REG_RD;
   logic       resetIF;
   logic [4:0] rs_id;
   logic [4:0] rt_id;
   logic [4:0] rd_id;

   logic       stall;
   logic       flush_if;
   logic [2:0] alu_fun_ex;
   logic       sel_alu_ex;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       mem_rd_mem;
   logic       mem_wr_mem;
   logic       w_h_mem;
   logic       dir_wb_wb;
   logic       reg_wr_wb;
   logic [4:0] dest_wb;

   modport master (
      output ctrl_EXE, ctrl_MEM, ctrl_WB, REG_RD, resetIF, rs_id, rt_id, rd_id,
      input  stall, flush_if, alu_fun_ex, sel_alu_ex, fwd_a, fwd_b,
             mem_rd_mem, mem_wr_mem, w_h_mem, dir_wb_wb, reg_wr_wb, dest_wb
   );

   modport slave (
      input  ctrl_EXE, ctrl_MEM, ctrl_WB, REG_RD, resetIF, rs_id, rt_id, rd_id,
      output stall, flush_if, alu_fun_ex, sel_alu_ex, fwd_a, fwd_b,
             mem_rd_mem, mem_wr_mem, w_h_mem, dir_wb_wb, reg_wr_wb, dest_wb
   );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_fwd_unit.sv
// fwd_unit: combinational ALU operand source selection for the EX stage.
`default_nettype none

module fwd_unit
   import pipe_pkg::*;
(
   input  reg_idx_t rs_ex_i,
   input  reg_idx_t rt_ex_i,
   input  reg_idx_t dest_mem_i,
   input  reg_idx_t dest_wb_i,
   input  logic     reg_wr_mem_i,
   input  logic     reg_wr_wb_i,
   output fwd_sel_t fwd_a_o,
   output fwd_sel_t fwd_b_o
);

   // EX/MEM holds the younger result, so it is checked first.
   function automatic fwd_sel_t pick(input reg_idx_t src);
      fwd_sel_t sel;
      sel = FWD_BANK;
      if (writes_reg(reg_wr_mem_i, dest_mem_i) && (dest_mem_i == src)) begin
         sel = FWD_EXMEM;
      end else if (writes_reg(reg_wr_wb_i, dest_wb_i) && (dest_wb_i == src)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   assign fwd_a_o = pick(rs_ex_i);
   assign fwd_b_o = pick(rt_ex_i);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: carries decoder control bundles through ID/EX, EX/MEM and MEM/WB,
// detects load-use hazards, inserts bubbles, and gates the IF/ID flush.
`default_nettype none

module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   id_ex_t   idex_q,  idex_d;
   ex_mem_t  exmem_q, exmem_d;
   mem_wb_t  memwb_q, memwb_d;

   id_ex_t   id_capture;
   logic     hazard;
   fwd_sel_t fwd_a;
   fwd_sel_t fwd_b;

   always_comb begin
      id_capture      = ID_EX_BUBBLE;
      id_capture.ex   = ex_ctrl_t'(bus.ctrl_EXE[4:1]);
      id_capture.mem  = mem_ctrl_t'(bus.ctrl_MEM);
      id_capture.wb   = wb_ctrl_t'(bus.ctrl_WB);
      id_capture.dest = bus.ctrl_EXE[0] ? bus.rd_id : bus.rt_id;
      id_capture.rs   = bus.rs_id;
      id_capture.rt   = bus.rt_id;
   end

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      hazard = 1'b0;
      if ((idex_q.mem.mem_rd == ACTIVO) && (idex_q.dest != '0) &&
          (bus.REG_RD == ACTIVO) &&
          ((idex_q.dest == bus.rs_id) || (idex_q.dest == bus.rt_id))) begin
         hazard = 1'b1;
      end
   end

   always_comb begin
      idex_d       = hazard ? ID_EX_BUBBLE : id_capture;
      exmem_d      = EX_MEM_BUBBLE;
      exmem_d.mem  = idex_q.mem;
      exmem_d.wb   = idex_q.wb;
      exmem_d.dest = idex_q.dest;
      memwb_d      = MEM_WB_BUBBLE;
      memwb_d.wb   = exmem_q.wb;
      memwb_d.dest = exmem_q.dest;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q  <= ID_EX_BUBBLE;
         exmem_q <= EX_MEM_BUBBLE;
         memwb_q <= MEM_WB_BUBBLE;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   fwd_unit u_fwd_unit (
      .rs_ex_i      (idex_q.rs),
      .rt_ex_i      (idex_q.rt),
      .dest_mem_i   (exmem_q.dest),
      .dest_wb_i    (memwb_q.dest),
      .reg_wr_mem_i (exmem_q.wb.reg_wr),
      .reg_wr_wb_i  (memwb_q.wb.reg_wr),
      .fwd_a_o      (fwd_a),
      .fwd_b_o      (fwd_b)
   );

   // A jump held behind a load must not flush until its stall has cleared.
   assign bus.stall      = hazard;
   assign bus.flush_if   = bus.resetIF & ~hazard;
   assign bus.fwd_a      = fwd_a;
   assign bus.fwd_b      = fwd_b;
   assign bus.alu_fun_ex = idex_q.ex.alu_fun;
   assign bus.sel_alu_ex = idex_q.ex.sel_alu;
   assign bus.mem_rd_mem = exmem_q.mem.mem_rd;
   assign bus.mem_wr_mem = exmem_q.mem.mem_wr;
   assign bus.w_h_mem    = exmem_q.mem.w_h;
   assign bus.dir_wb_wb  = memwb_q.wb.dir_wb;
   assign bus.reg_wr_wb  = memwb_q.wb.reg_wr;
   assign bus.dest_wb    = memwb_q.dest;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against an
// instruction-history reference model.
`default_nettype none

module tb_pipe_ctrl;

   logic clk;
   logic rst;
   pipe_ctrl_if bus();

   pipe_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] alu;
      logic       sel_alu;
      logic       mem_rd;
      logic       mem_wr;
      logic       w_h;
      logic       dir_wb;
      logic       reg_wr;
      logic [4:0] dest;
      logic [4:0] rs;
      logic [4:0] rt;
   } instr_t;

   // hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
   instr_t hist[$];
   int     passed;
   int     total;

   function automatic instr_t bubble();
      instr_t b;
      b.alu = 3'b000; b.sel_alu = 1'b0;
      b.mem_rd = 1'b1; b.mem_wr = 1'b1; b.w_h = 1'b0;
      b.dir_wb = 1'b1; b.reg_wr = 1'b1;
      b.dest = 5'd0; b.rs = 5'd0; b.rt = 5'd0;
      return b;
   endfunction

   function automatic instr_t from_id();
      instr_t n;
      n.alu     = bus.ctrl_EXE[4:2];
      n.sel_alu = bus.ctrl_EXE[1];
      n.mem_rd  = bus.ctrl_MEM[2];
      n.mem_wr  = bus.ctrl_MEM[1];
      n.w_h     = bus.ctrl_MEM[0];
      n.dir_wb  = bus.ctrl_WB[1];
      n.reg_wr  = bus.ctrl_WB[0];
      n.dest    = bus.ctrl_EXE[0] ? bus.rd_id : bus.rt_id;
      n.rs      = bus.rs_id;
      n.rt      = bus.rt_id;
      return n;
   endfunction

   function automatic logic model_stall();
      return (hist[0].mem_rd == 1'b0) && (hist[0].dest != 0) && (bus.REG_RD == 1'b0) &&
             ((hist[0].dest == bus.rs_id) || (hist[0].dest == bus.rt_id));
   endfunction

   function automatic logic [1:0] model_fwd(input logic [4:0] src);
      if (hist[1].reg_wr == 1'b0 && hist[1].dest != 0 && hist[1].dest == src) return 2'b10;
      if (hist[2].reg_wr == 1'b0 && hist[2].dest != 0 && hist[2].dest == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
   endtask

   task automatic compare_all();
      chk("stall",    16'(bus.stall),    16'(model_stall()));
      chk("flush_if", 16'(bus.flush_if), 16'(bus.resetIF & ~model_stall()));
      chk("fwd",      16'({bus.fwd_a, bus.fwd_b}),
                      16'({model_fwd(hist[0].rs), model_fwd(hist[0].rt)}));
      chk("ex_ctrl",  16'({bus.alu_fun_ex, bus.sel_alu_ex}), 16'({hist[0].alu, hist[0].sel_alu}));
      chk("mem_ctrl", 16'({bus.mem_rd_mem, bus.mem_wr_mem, bus.w_h_mem}),
                      16'({hist[1].mem_rd, hist[1].mem_wr, hist[1].w_h}));
      chk("wb_ctrl",  16'({bus.dir_wb_wb, bus.reg_wr_wb, bus.dest_wb}),
                      16'({hist[2].dir_wb, hist[2].reg_wr, hist[2].dest}));
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (3) hist.push_back(bubble());
   endtask

   // Inputs are already applied; check mid-cycle, then advance across the edge.
   task automatic cycle();
      instr_t nxt;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         nxt = model_stall() ? bubble() : from_id();
         hist.push_front(nxt);
         void'(hist.pop_back());
      end
      #1;
   endtask

   task automatic drive(input logic [4:0] exe, input logic [2:0] mem, input logic [1:0] wb,
                        input logic reg_rd, input logic rif,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      bus.ctrl_EXE = exe; bus.ctrl_MEM = mem; bus.ctrl_WB = wb;
      bus.REG_RD = reg_rd; bus.resetIF = rif;
      bus.rs_id = rs; bus.rt_id = rt; bus.rd_id = rd;
   endtask

   task automatic drive_random(input int reg_span);
      bus.ctrl_EXE = 5'($urandom);
      bus.ctrl_MEM = 3'($urandom);
      bus.ctrl_WB  = 2'($urandom);
      bus.REG_RD   = ($urandom_range(0, 3) == 0);
      bus.resetIF  = ($urandom_range(0, 3) == 0);
      bus.rs_id    = 5'($urandom_range(0, reg_span));
      bus.rt_id    = 5'($urandom_range(0, reg_span));
      bus.rd_id    = 5'($urandom_range(0, reg_span));
   endtask

   localparam logic [4:0] EXE_ADD = 5'b001_0_1;
   localparam logic [4:0] EXE_LW  = 5'b001_1_0;
   localparam logic [4:0] EXE_NOP = 5'b000_0_0;
   localparam logic [2:0] MEM_NONE = 3'b110;
   localparam logic [2:0] MEM_LW   = 3'b011;
   localparam logic [2:0] MEM_SW   = 3'b101;
   localparam logic [1:0] WB_ALU  = 2'b10;
   localparam logic [1:0] WB_LOAD = 2'b00;
   localparam logic [1:0] WB_NONE = 2'b11;

   initial begin
      passed = 0;
      total  = 0;

      // Reset held two cycles under random inputs.
      rst = 1'b1;
      drive_random(31);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      drive_random(31);
      bus.resetIF = 1'b0;
      #1;
      chk("rst_stall",  16'(bus.stall), 16'h0);
      chk("rst_flush",  16'(bus.flush_if), 16'h0);
      chk("rst_fwd",    16'({bus.fwd_a, bus.fwd_b}), 16'h0);
      chk("rst_ex",     16'({bus.alu_fun_ex, bus.sel_alu_ex}), 16'h0);
      chk("rst_mem",    16'({bus.mem_rd_mem, bus.mem_wr_mem, bus.w_h_mem}), 16'b110);
      chk("rst_wb",     16'({bus.dir_wb_wb, bus.reg_wr_wb, bus.dest_wb}), 16'({2'b11, 5'd0}));

      // Propagation of an add to r5.
      drive(EXE_ADD, MEM_NONE, WB_ALU, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
      cycle();
      chk("prop_alu_ex", 16'(bus.alu_fun_ex), 16'h1);
      drive(EXE_NOP, MEM_NONE, WB_NONE, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle();
      cycle();
      chk("prop_wb", 16'({bus.reg_wr_wb, bus.dest_wb}), 16'({1'b0, 5'd5}));

      // Load-use: lw r8 then add reading r8.
      drive(EXE_LW, MEM_LW, WB_LOAD, 1'b0, 1'b0, 5'd1, 5'd8, 5'd0);
      cycle();
      drive(EXE_ADD, MEM_NONE, WB_ALU, 1'b0, 1'b0, 5'd8, 5'd2, 5'd9);
      #1;
      chk("lu_stall", 16'(bus.stall), 16'h1);
      cycle();
      chk("lu_stall_clear", 16'(bus.stall), 16'h0);
      chk("lu_bubble_ex", 16'(bus.alu_fun_ex), 16'h0);
      cycle();
      chk("lu_fwd_a", 16'(bus.fwd_a), 16'b01);
      chk("lu_bubble_mem", 16'(bus.mem_wr_mem), 16'h1);

      // Forward priority: two writes to r3, then a read of r3; repeat for r0.
      drive(EXE_ADD, MEM_NONE, WB_ALU, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
      cycle();
      cycle();
      drive(EXE_ADD, MEM_NONE, WB_ALU, 1'b0, 1'b0, 5'd3, 5'd4, 5'd6);
      cycle();
      chk("prio_fwd_a", 16'(bus.fwd_a), 16'b10);
      drive(EXE_ADD, MEM_NONE, WB_ALU, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
      cycle();
      cycle();
      drive(EXE_ADD, MEM_NONE, WB_ALU, 1'b0, 1'b0, 5'd0, 5'd4, 5'd6);
      cycle();
      chk("r0_fwd_a", 16'(bus.fwd_a), 16'b00);

      // jr on a just-loaded register.
      drive(EXE_LW, MEM_LW, WB_LOAD, 1'b0, 1'b0, 5'd1, 5'd8, 5'd0);
      cycle();
      drive(EXE_NOP, MEM_NONE, WB_NONE, 1'b0, 1'b1, 5'd8, 5'd0, 5'd0);
      #1;
      chk("jr_stall", 16'({bus.stall, bus.flush_if}), 16'b10);
      cycle();
      chk("jr_flush", 16'({bus.stall, bus.flush_if}), 16'b01);
      drive(EXE_NOP, MEM_NONE, WB_NONE, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle();

      // Reset while a sw sits in EX/MEM.
      drive(EXE_LW, MEM_SW, WB_NONE, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      cycle();
      drive(EXE_NOP, MEM_NONE, WB_NONE, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle();
      chk("sw_in_mem", 16'(bus.mem_wr_mem), 16'h0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid_mem_wr", 16'(bus.mem_wr_mem), 16'h1);

      // Randomized traffic over a small register set to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         drive_random(3);
         rst = ($urandom_range(0, 39) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
